// File: rtl/dma_copy_master_pkg.sv
// Shared bus command codes, I/O window addresses and FSM state encoding for the copy master.
// Imported by the CPU-side decode as well as the DMA block.
package dma_copy_master_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] LEDADDR = 9'h100;
    localparam logic [8:0] SWADDR  = 9'h140;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: source/destination pointers and remaining-word count for one copy.
// Latency: pointers update on the edge their enable is high; last is combinational from remaining.
// Backpressure: none; the FSM owns all sequencing.
module dma_addr_gen #(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              src_inc,
    input  logic              dst_step,
    output logic [ADDR_W-1:0] cur_src,
    output logic [ADDR_W-1:0] cur_dst,
    output logic              last
);

    logic [LEN_W-1:0] remaining;

    assign last = (remaining == LEN_W'(1));

    // Pointers wrap naturally at 2^ADDR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_src   <= src;
            cur_dst   <= dst;
            remaining <= len;
        end else begin
            if (src_inc) begin
                cur_src <= cur_src + 1'b1;
            end
            if (dst_step) begin
                cur_dst   <= cur_dst + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_copy_master.sv
// dma_copy_master: block copy initiator on the shared memory bus; DMA_COPY_CHECKSUM_EN adds a read-word checksum port.
// Latency: 3 cycles per word (MREAD, MREAD, MWRITE), done pulses the cycle after the last write.
// Backpressure: none; bus grant is external, start is sampled only in IDLE and never queued.
module dma_copy_master
    import dma_copy_master_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
`ifdef DMA_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            state;
    state_t            nxt;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] cur_src;
    logic [ADDR_W-1:0] cur_dst;
    logic              last;
    logic              accept;

    assign accept = (state == IDLE) && start;

    dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .src_inc  (state == RD_DATA),
        .dst_step (state == WR),
        .cur_src  (cur_src),
        .cur_dst  (cur_dst),
        .last     (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (len == '0) ? DONE : RD_ADDR;
            RD_ADDR: nxt = RD_DATA;
            RD_DATA: nxt = WR;
            WR:      nxt = last ? DONE : RD_ADDR;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Bus outputs decode from registered state only, so they cannot glitch on input changes.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        case (state)
            RD_ADDR, RD_DATA: begin
                busy     = 1'b1;
                mem_cmd  = MREAD;
                mem_addr = cur_src;
            end
            WR: begin
                busy       = 1'b1;
                mem_cmd    = MWRITE;
                mem_addr   = cur_dst;
                write_data = data_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Synchronous-read RAM returns data the cycle after the address, i.e. during RD_DATA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (state == RD_DATA) begin
            data_q <= read_data;
        end
    end

`ifdef DMA_COPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (state == RD_DATA) begin
            checksum <= checksum + read_data;
        end
    end
`endif

endmodule
